// File: rtl/mult_share_arb_pkg.sv
// rtl/mult_share_arb_pkg.sv - shared defaults and requester IDs for the multiplier arbiter
package mult_arb_pkg;

  localparam int NREQ_DEF = 3;
  localparam int A_W_DEF  = 16;
  localparam int B_W_DEF  = 28;
  localparam int LAT_DEF  = 2;

  typedef enum logic [1:0] {
    REQ_DET = 2'd0,
    REQ_QKV = 2'd1,
    REQ_ATT = 2'd2
  } req_id_e;

  // Tag width for a requester index; a single requester still needs one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mult_share_arb_if.sv
// rtl/mult_share_arb_if.sv - request/response bus between requesters and the shared multiplier
interface mult_share_arb_if
  import mult_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int A_W  = A_W_DEF,
  parameter int B_W  = B_W_DEF
);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*A_W-1:0]   req_a;
  logic [NREQ*B_W-1:0]   req_b;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       rsp_valid;
  logic [A_W+B_W-1:0]    rsp_z;
  logic                  busy;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_z, busy
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_z, busy
  );

endinterface

// File: rtl/mult_share_arb_pipe.sv
// rtl/mult_share_arb_pipe.sv - mult_pipe: LAT-stage signed multiplier carrying valid and requester tag
module mult_pipe #(
  parameter int A_W = 16,
  parameter int B_W = 28,
  parameter int LAT = 2,
  parameter int IDW = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_clr,
  input  logic                      i_valid,
  input  logic [IDW-1:0]            i_id,
  input  logic signed [A_W-1:0]     i_a,
  input  logic signed [B_W-1:0]     i_b,
  output logic                      o_valid,
  output logic [IDW-1:0]            o_id,
  output logic signed [A_W+B_W-1:0] o_z,
  output logic                      o_busy
);

  localparam int Z_W = A_W + B_W;

  logic [LAT-1:0]          r_vld;
  logic [IDW-1:0]          r_id [LAT];
  logic signed [Z_W-1:0]   r_z  [LAT];
  logic signed [Z_W-1:0]   w_prod;

  assign w_prod = Z_W'(i_a) * Z_W'(i_b);

  // Product registers hold zero whenever their stage is empty, so o_z is 0 without a valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int i = 0; i < LAT; i++) begin
        r_id[i] <= '0;
        r_z[i]  <= '0;
      end
    end else if (i_clr) begin
      r_vld <= '0;
      for (int i = 0; i < LAT; i++) begin
        r_id[i] <= '0;
        r_z[i]  <= '0;
      end
    end else begin
      r_vld[0] <= i_valid;
      r_id[0]  <= i_valid ? i_id : '0;
      r_z[0]   <= i_valid ? w_prod : '0;
      for (int i = 1; i < LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_id[i]  <= r_id[i-1];
        r_z[i]   <= r_z[i-1];
      end
    end
  end

  assign o_valid = r_vld[LAT-1];
  assign o_id    = r_id[LAT-1];
  assign o_z     = r_z[LAT-1];
  assign o_busy  = |r_vld;

endmodule

// File: rtl/mult_share_arb.sv
// rtl/mult_share_arb.sv - round-robin arbiter sharing one pipelined multiplier; MULT_ARB_PRIO0_EN gives requester 0 strict priority
module mult_share_arb
  import mult_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int A_W  = A_W_DEF,
  parameter int B_W  = B_W_DEF,
  parameter int LAT  = LAT_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           sync_clr,
  mult_share_arb_if.slave bus
);

  localparam int IDW = id_w(NREQ);

`ifdef MULT_ARB_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  logic [IDW-1:0]            r_rr_ptr;
  logic [NREQ-1:0]           w_grant;
  logic [IDW-1:0]            w_gid;
  logic                      w_gnt_any;
  logic                      w_accept;
  logic signed [A_W-1:0]     w_a;
  logic signed [B_W-1:0]     w_b;
  logic                      w_pipe_vld;
  logic [IDW-1:0]            w_pipe_id;
  logic signed [A_W+B_W-1:0] w_pipe_z;
  logic                      w_busy;

  // Search starts at r_rr_ptr; with priority enabled requester 0 bypasses the rotation.
  always_comb begin
    int idx;
    idx       = 0;
    w_grant   = '0;
    w_gid     = '0;
    w_gnt_any = 1'b0;
    if (PRIO0 && bus.req_valid[REQ_DET]) begin
      w_gnt_any = 1'b1;
      w_gid     = '0;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        idx = int'(r_rr_ptr) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        if (!w_gnt_any && bus.req_valid[idx] && !(PRIO0 && idx == int'(REQ_DET))) begin
          w_gnt_any = 1'b1;
          w_gid     = IDW'(idx);
        end
      end
    end
    if (w_gnt_any) w_grant[w_gid] = 1'b1;
  end

  assign w_accept      = w_gnt_any && rst_n && !sync_clr;
  assign bus.req_ready = w_accept ? w_grant : '0;
  assign w_a           = bus.req_a[int'(w_gid)*A_W +: A_W];
  assign w_b           = bus.req_b[int'(w_gid)*B_W +: B_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (sync_clr) begin
      r_rr_ptr <= '0;
    end else if (w_accept) begin
      r_rr_ptr <= (w_gid == IDW'(NREQ-1)) ? '0 : w_gid + 1'b1;
    end
  end

  mult_pipe #(
    .A_W (A_W),
    .B_W (B_W),
    .LAT (LAT),
    .IDW (IDW)
  ) u_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (sync_clr),
    .i_valid (w_accept),
    .i_id    (w_gid),
    .i_a     (w_a),
    .i_b     (w_b),
    .o_valid (w_pipe_vld),
    .o_id    (w_pipe_id),
    .o_z     (w_pipe_z),
    .o_busy  (w_busy)
  );

  always_comb begin
    bus.rsp_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus.rsp_valid[i] = w_pipe_vld && (w_pipe_id == IDW'(i));
    end
  end

  assign bus.rsp_z = w_pipe_z;
  assign bus.busy  = w_busy;

endmodule

// File: tb/tb_mult_share_arb.sv
// tb/tb_mult_share_arb.sv - scoreboard bench for mult_share_arb against a behavioural arbitration model
module tb_mult_share_arb;
  import mult_arb_pkg::*;

  localparam int NREQ = 3;
  localparam int A_W  = 16;
  localparam int B_W  = 28;
  localparam int LAT  = 2;

  typedef struct {
    int     due;
    int     id;
    longint z;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sync_clr = 1'b0;

  always #5 clk = ~clk;

  mult_share_arb_if #(.NREQ(NREQ), .A_W(A_W), .B_W(B_W)) bus ();

  mult_share_arb #(.NREQ(NREQ), .A_W(A_W), .B_W(B_W), .LAT(LAT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sync_clr (sync_clr),
    .bus      (bus)
  );

  int     errors = 0;
  int     checks = 0;
  int     cyc = 0;
  int     rr = 0;
  bit     acc [NREQ];
  exp_t   q [$];
  int     dut_log [$];
  exp_t   mon_e;
  logic signed [A_W-1:0] m_a;
  logic signed [B_W-1:0] m_b;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard whenever a response is due and compares the DUT outputs.
  always @(posedge clk) begin
    #3;
    if (!rst_n) begin
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_z", bus.rsp_z, 0);
      chk("rst_busy", bus.busy, 0);
    end else begin
      chk("busy", bus.busy, (q.size() != 0) ? 1 : 0);
      if (q.size() > 0 && q[0].due <= cyc) begin
        mon_e = q.pop_front();
        chk("rsp_valid", bus.rsp_valid, longint'(1) << mon_e.id);
        chk("rsp_z", $signed(bus.rsp_z), mon_e.z);
      end else begin
        chk("rsp_valid_idle", bus.rsp_valid, 0);
        chk("rsp_z_idle", bus.rsp_z, 0);
      end
    end
  end

  // Reference model: decides the grant from the arbitration rules and queues the expected product.
  always @(negedge clk) begin
    int g;
    int idx;
    if (!rst_n) begin
      q.delete();
      rr = 0;
      for (int i = 0; i < NREQ; i++) acc[i] = 1'b0;
      chk("rst_req_ready", bus.req_ready, 0);
    end else if (sync_clr) begin
      q.delete();
      rr = 0;
      for (int i = 0; i < NREQ; i++) acc[i] = 1'b0;
      chk("clr_req_ready", bus.req_ready, 0);
    end else begin
      g = -1;
`ifdef MULT_ARB_PRIO0_EN
      if (bus.req_valid[0]) g = 0;
`endif
      for (int k = 0; k < NREQ && g < 0; k++) begin
        idx = (rr + k) % NREQ;
`ifdef MULT_ARB_PRIO0_EN
        if (idx != 0 && bus.req_valid[idx]) g = idx;
`else
        if (bus.req_valid[idx]) g = idx;
`endif
      end
      chk("req_ready", bus.req_ready, (g < 0) ? 0 : (longint'(1) << g));
      for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) dut_log.push_back(i);
      if (g >= 0) begin
        m_a = bus.req_a[g*A_W +: A_W];
        m_b = bus.req_b[g*B_W +: B_W];
        q.push_back('{cyc + LAT, g, longint'(m_a) * longint'(m_b)});
        rr = (g + 1) % NREQ;
        acc[g] = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic signed [A_W-1:0] a, input logic signed [B_W-1:0] b);
    bus.req_a[i*A_W +: A_W] = a;
    bus.req_b[i*B_W +: B_W] = b;
  endtask

  function automatic logic signed [A_W-1:0] rand_a();
    int r = $urandom_range(0, 9);
    if (r == 0) return -(2**(A_W-1));
    if (r == 1) return (2**(A_W-1)) - 1;
    return A_W'($urandom);
  endfunction

  function automatic logic signed [B_W-1:0] rand_b();
    int r = $urandom_range(0, 9);
    if (r == 0) return -(2**(B_W-1));
    if (r == 1) return (2**(B_W-1)) - 1;
    return B_W'($urandom);
  endfunction

  // A requester that is idle or was just accepted takes its new decision; others hold.
  task automatic drive(input logic [NREQ-1:0] want);
    for (int i = 0; i < NREQ; i++) begin
      if (!bus.req_valid[i] || acc[i]) begin
        bus.req_valid[i] = want[i];
        set_ops(i, rand_a(), rand_b());
      end
      acc[i] = 1'b0;
    end
  endtask

  task automatic idle();
    bus.req_valid = '0;
    for (int i = 0; i < NREQ; i++) acc[i] = 1'b0;
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    for (int i = 0; i < NREQ; i++) acc[i] = 1'b0;
    #2;
    chk("reset_req_ready", bus.req_ready, 0);
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_rsp_z", bus.rsp_z, 0);
    chk("reset_busy", bus.busy, 0);
    repeat (3) tick();

    // All requesters valid from reset release: strict rotation 0,1,2,...
    rst_n = 1'b1;
    dut_log.delete();
    drive(3'b111);
    for (int n = 0; n < 8; n++) begin
      tick();
      drive(3'b111);
    end
    chk("rr_log_size", (dut_log.size() >= 6) ? 1 : 0, 1);
    for (int n = 0; n < 6 && n < dut_log.size(); n++) chk("rr_order", dut_log[n], n % NREQ);
    idle();
    repeat (4) tick();

    // Single requester 1: -3 * 1000
    set_ops(1, -3, 1000);
    bus.req_valid = 3'b010;
    #1 chk("single_ready", bus.req_ready, 3'b010);
    tick();
    idle();
    tick();
    #1;
    chk("single_rsp_valid", bus.rsp_valid, 3'b010);
    chk("single_rsp_z", $signed(bus.rsp_z), -3000);
    repeat (2) tick();

    // Extreme operands
    set_ops(2, -32768, -134217728);
    bus.req_valid = 3'b100;
    tick();
    idle();
    tick();
    #1;
    chk("extreme_rsp_valid", bus.rsp_valid, 3'b100);
    chk("extreme_rsp_z", $signed(bus.rsp_z), 64'sd4398046511104);
    repeat (2) tick();

    // Two in flight, then a one-cycle flush
    drive(3'b011);
    tick();
    drive(3'b010);
    tick();
    sync_clr = 1'b1;
    bus.req_valid = 3'b111;
    for (int i = 0; i < NREQ; i++) acc[i] = 1'b0;
    #1 chk("clr_ready_masked", bus.req_ready, 0);
    tick();
    sync_clr = 1'b0;
    #1;
    chk("clr_no_rsp", bus.rsp_valid, 0);
    chk("clr_busy_low", bus.busy, 0);
    chk("clr_next_grant", bus.req_ready, 3'b001);
    tick();
    drive(3'b111);
    tick();
    idle();
    repeat (4) tick();

    // Asynchronous reset with a busy pipeline
    drive(3'b111);
    repeat (3) begin
      tick();
      drive(3'b111);
    end
    rst_n = 1'b0;
    #1;
    chk("async_rst_req_ready", bus.req_ready, 0);
    chk("async_rst_rsp_valid", bus.rsp_valid, 0);
    chk("async_rst_rsp_z", bus.rsp_z, 0);
    chk("async_rst_busy", bus.busy, 0);
    repeat (2) tick();
    idle();
    rst_n = 1'b1;
    repeat (4) tick();

`ifdef MULT_ARB_PRIO0_EN
    for (int n = 0; n < 5; n++) begin
      drive(3'b011);
      #1 chk("prio0_grant", bus.req_ready, 3'b001);
      tick();
    end
    bus.req_valid[0] = 1'b0;
    for (int i = 0; i < NREQ; i++) acc[i] = 1'b0;
    #1 chk("prio0_release", bus.req_ready, 3'b010);
    tick();
    idle();
    repeat (4) tick();
`endif

    // Randomized traffic with occasional flushes
    for (int n = 0; n < 400; n++) begin
      logic [NREQ-1:0] want;
      for (int i = 0; i < NREQ; i++) want[i] = ($urandom_range(0, 3) != 0);
      sync_clr = ($urandom_range(0, 39) == 0);
      drive(want);
      tick();
    end
    sync_clr = 1'b0;
    idle();
    repeat (LAT + 3) tick();
    chk("drain", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
